// File: rtl/instr_fetch_decode_if.sv
// instr_fetch_decode_if: ROM read bus plus decoded-instruction valid/ready bus.
// master = fetch/decode unit; slave = ROM + execute-stage side.
interface instr_fetch_decode_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [4:0]  out_dst;
  logic [4:0]  out_src_a;
  logic [4:0]  out_src_b;
  logic [31:0] out_imm;
  logic [2:0]  out_class;

  modport master (
    output imem_addr,
    input  imem_data,
    output out_valid,
    input  out_ready,
    output out_pc,
    output out_instr,
    output out_dst,
    output out_src_a,
    output out_src_b,
    output out_imm,
    output out_class
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    input  out_valid,
    output out_ready,
    input  out_pc,
    input  out_instr,
    input  out_dst,
    input  out_src_a,
    input  out_src_b,
    input  out_imm,
    input  out_class
  );
endinterface

// File: rtl/instr_fetch_decode.sv
// instr_fetch_decode: PC + ROM fetch, field split, class decode, valid/ready out.
// Ports: clk, rst (async high), start; bus (imem_*, out_*); busy, halted, illegal.
// Optional IFD_ILLEGAL_TRAP_EN: unknown nonzero word raises illegal and halts.
module instr_fetch_decode #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] PC_STEP  = 32'd4,
  parameter logic [31:0] MAX_PC   = 32'd1020
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  instr_fetch_decode_if.master bus,
  output logic busy,
  output logic halted,
  output logic illegal
);

  localparam logic [2:0] C_NONE = 3'd0;
  localparam logic [2:0] C_LW   = 3'd1;
  localparam logic [2:0] C_SW   = 3'd2;
  localparam logic [2:0] C_ADD  = 3'd3;
  localparam logic [2:0] C_MUL  = 3'd4;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    HALT
  } state_t;

  state_t state, state_nx;

  logic [31:0] pc;
  logic [31:0] w;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic [2:0]  cls;
  logic        is_zero;
  logic        is_last;
  logic        trap;
  logic        load;
  logic        restart;
  logic        clr_valid;

  assign w       = bus.imem_data;
  assign op      = w[31:26];
  assign funct   = w[5:0];
  assign is_zero = (w == 32'd0);
  assign is_last = (pc == MAX_PC);

  assign bus.imem_addr = pc;
  assign busy   = (state == FETCH) || (state == DRAIN);
  assign halted = (state == HALT);

  always_comb begin
    cls = C_NONE;
    unique case (1'b1)
      (op == 6'b100011): cls = C_LW;
      (op == 6'b101011): cls = C_SW;
      (op == 6'b000000 && funct == 6'b100000): cls = C_ADD;
      (op == 6'b000000 && funct == 6'b011000): cls = C_MUL;
      default: cls = C_NONE;
    endcase
  end

`ifdef IFD_ILLEGAL_TRAP_EN
  logic ill_q;

  // load only fires on nonzero words, so NONE here means an unknown opcode
  assign trap    = (cls == C_NONE);
  assign illegal = ill_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ill_q <= 1'b0;
    end else if (restart) begin
      ill_q <= 1'b0;
    end else if (load) begin
      ill_q <= trap;
    end
  end
`else
  assign trap    = 1'b0;
  assign illegal = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    load      = 1'b0;
    restart   = 1'b0;
    clr_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          restart  = 1'b1;
          state_nx = FETCH;
        end
      end
      FETCH: begin
        if (!bus.out_valid || bus.out_ready) begin
          if (is_zero) begin
            // slot is free or being accepted: nothing stays pending
            clr_valid = 1'b1;
            state_nx  = DRAIN;
          end else begin
            load = 1'b1;
            if (is_last || trap) begin
              state_nx = DRAIN;
            end
          end
        end
      end
      DRAIN: begin
        if (!bus.out_valid) begin
          state_nx = HALT;
        end else if (bus.out_ready) begin
          clr_valid = 1'b1;
        end
      end
      HALT: begin
        if (start) begin
          restart  = 1'b1;
          state_nx = FETCH;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc            <= RESET_PC;
      bus.out_valid <= 1'b0;
      bus.out_pc    <= 32'd0;
      bus.out_instr <= 32'd0;
      bus.out_dst   <= 5'd0;
      bus.out_src_a <= 5'd0;
      bus.out_src_b <= 5'd0;
      bus.out_imm   <= 32'd0;
      bus.out_class <= 3'd0;
    end else begin
      if (restart) begin
        pc <= RESET_PC;
      end
      if (load) begin
        bus.out_valid <= 1'b1;
        bus.out_pc    <= pc;
        bus.out_instr <= w;
        bus.out_dst   <= w[25:21];
        bus.out_src_a <= w[20:16];
        bus.out_src_b <= w[15:11];
        bus.out_imm   <= {{16{w[15]}}, w[15:0]};
        bus.out_class <= cls;
        // the final address is fetched once; PC parks there
        if (!is_last) begin
          pc <= pc + PC_STEP;
        end
      end
      if (clr_valid) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_decode.sv
// tb_instr_fetch_decode: directed vectors for fetch/decode front end.
// Combinational ROM model; queues record each accepted instruction.
module tb_instr_fetch_decode;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy;
  logic halted;
  logic illegal;

  instr_fetch_decode_if bus();

  instr_fetch_decode dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bus     (bus),
    .busy    (busy),
    .halted  (halted),
    .illegal (illegal)
  );

  always #5 clk = ~clk;

  logic [31:0] rom [256];
  assign bus.imem_data = rom[bus.imem_addr[9:2]];

  int nvec = 0;
  int nerr = 0;

  logic [31:0] prog [10];
  logic [31:0] q_pc  [$];
  logic [31:0] q_ins [$];
  logic [2:0]  q_cls [$];
  logic        q_ill [$];
  logic [46:0] q_f   [$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 32'd0;
  endtask

  task automatic load_prog();
    clear_rom();
    for (int i = 0; i < 10; i++) rom[i] = prog[i];
  endtask

  task automatic capture(input int maxc, output bit done);
    q_pc.delete();
    q_ins.delete();
    q_cls.delete();
    q_ill.delete();
    q_f.delete();
    for (int c = 0; c < maxc; c++) begin
      if (halted) break;
      if (bus.out_valid && bus.out_ready) begin
        q_pc.push_back(bus.out_pc);
        q_ins.push_back(bus.out_instr);
        q_cls.push_back(bus.out_class);
        q_ill.push_back(illegal);
        q_f.push_back({bus.out_dst, bus.out_src_a,
                       bus.out_src_b, bus.out_imm});
      end
      step();
    end
    done = halted;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    bus.out_ready = 1'b0;
    step();
    step();
    nvec++;
    if ({bus.out_valid, busy, halted, illegal} !== 4'b0) begin
      nerr++;
      $display("FAIL reset_flags: got %b want 0000",
               {bus.out_valid, busy, halted, illegal});
    end
    nvec++;
    if ({bus.imem_addr, bus.out_pc, bus.out_instr} !== 96'd0) begin
      nerr++;
      $display("FAIL reset_regs: addr=%h pc=%h instr=%h want 0",
               bus.imem_addr, bus.out_pc, bus.out_instr);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_first_fetch();
    load_prog();
    pulse_start();
    nvec++;
    if ({bus.imem_addr, busy, bus.out_valid} !== {32'd0, 1'b1, 1'b0}) begin
      nerr++;
      $display("FAIL start_edge: addr=%h busy=%b valid=%b want 0 1 0",
               bus.imem_addr, busy, bus.out_valid);
    end
    step();
    nvec++;
    if ({bus.out_valid, bus.out_pc, bus.out_class, bus.out_dst,
         bus.out_src_a, bus.out_imm} !==
        {1'b1, 32'd0, 3'd1, 5'd8, 5'd16, 32'h200}) begin
      nerr++;
      $display("FAIL first_lw: v=%b pc=%h cls=%0d d=%0d a=%0d imm=%h",
               bus.out_valid, bus.out_pc, bus.out_class, bus.out_dst,
               bus.out_src_a, bus.out_imm);
    end
  endtask

  task automatic test_stall_hold();
    for (int i = 0; i < 3; i++) begin
      step();
      nvec++;
      if ({bus.out_valid, bus.out_pc, bus.out_instr, bus.imem_addr} !==
          {1'b1, 32'd0, 32'h8D100200, 32'd4}) begin
        nerr++;
        $display("FAIL stall_hold%0d: v=%b pc=%h ins=%h addr=%h", i,
                 bus.out_valid, bus.out_pc, bus.out_instr, bus.imem_addr);
      end
    end
  endtask

  task automatic test_stream();
    bit done;
    bus.out_ready = 1'b1;
    capture(40, done);
    nvec++;
    if (!done || q_pc.size() != 9) begin
      nerr++;
      $display("FAIL stream_count: done=%b n=%0d want 1 9", done, q_pc.size());
    end
    for (int i = 0; i < 9; i++) begin
      nvec++;
      if ({q_pc[i], q_ins[i]} !== {32'(i * 4), prog[i]}) begin
        nerr++;
        $display("FAIL stream_item%0d: pc=%h ins=%h want %h %h", i,
                 q_pc[i], q_ins[i], i * 4, prog[i]);
      end
    end
    nvec++;
    if ({q_cls[2], q_f[2]} !== {3'd4, 5'd14, 5'd8, 5'd9, 32'h4818}) begin
      nerr++;
      $display("FAIL mul_decode: cls=%0d f=%h", q_cls[2], q_f[2]);
    end
    nvec++;
    if ({q_cls[8], q_f[8]} !== {3'd2, 5'd14, 5'd16, 5'd0, 32'h100}) begin
      nerr++;
      $display("FAIL sw_decode: cls=%0d f=%h", q_cls[8], q_f[8]);
    end
    nvec++;
    if ({halted, bus.out_valid, busy} !== 3'b100) begin
      nerr++;
      $display("FAIL stream_halt: h/v/b=%b want 100",
               {halted, bus.out_valid, busy});
    end
  endtask

  task automatic test_stall_mid();
    bit done;
    bus.out_ready = 1'b1;
    pulse_start();
    step();
    step();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      nvec++;
      if ({bus.out_valid, bus.out_pc, bus.imem_addr} !==
          {1'b1, 32'd4, 32'd8}) begin
        nerr++;
        $display("FAIL mid_stall%0d: v=%b pc=%h addr=%h want 1 4 8", i,
                 bus.out_valid, bus.out_pc, bus.imem_addr);
      end
    end
    bus.out_ready = 1'b1;
    capture(40, done);
    nvec++;
    if (!done || q_pc.size() != 8) begin
      nerr++;
      $display("FAIL mid_count: done=%b n=%0d want 1 8", done, q_pc.size());
    end
    for (int i = 0; i < 3; i++) begin
      nvec++;
      if (q_pc[i] !== 32'(4 + i * 4)) begin
        nerr++;
        $display("FAIL mid_seq%0d: pc=%h want %h", i, q_pc[i], 4 + i * 4);
      end
    end
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b1;
    pulse_start();
    step();
    step();
    bus.out_ready = 1'b0;
    step();
    #2;
    rst = 1'b1;
    #1;
    nvec++;
    if ({bus.out_valid, busy, bus.out_pc, bus.out_instr, bus.imem_addr}
        !== 98'd0) begin
      nerr++;
      $display("FAIL async_rst: v=%b busy=%b pc=%h ins=%h addr=%h want 0",
               bus.out_valid, busy, bus.out_pc, bus.out_instr, bus.imem_addr);
    end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_eop();
    bit done;
    clear_rom();
    rom[0] = 32'h8D100200;
    rom[1] = 32'h00611020;
    rom[2] = 32'h01C84818;
    bus.out_ready = 1'b1;
    pulse_start();
    capture(40, done);
    nvec++;
    if (!done || q_pc.size() != 3 || q_pc[2] !== 32'd8) begin
      nerr++;
      $display("FAIL eop_count: done=%b n=%0d want 1 3", done, q_pc.size());
    end
    nvec++;
    if ({halted, bus.out_valid} !== 2'b10) begin
      nerr++;
      $display("FAIL eop_halt: h/v=%b want 10", {halted, bus.out_valid});
    end
    pulse_start();
    capture(40, done);
    nvec++;
    if (!done || q_pc.size() != 3 || q_pc[0] !== 32'd0) begin
      nerr++;
      $display("FAIL eop_replay: done=%b n=%0d pc0=%h want 1 3 0",
               done, q_pc.size(), q_pc[0]);
    end
  endtask

  task automatic test_illegal();
    bit done;
    clear_rom();
    rom[0] = 32'h00611020;
    rom[1] = 32'hFC000000;
    rom[2] = 32'h00611020;
    bus.out_ready = 1'b1;
    pulse_start();
    capture(40, done);
`ifdef IFD_ILLEGAL_TRAP_EN
    nvec++;
    if (!done || q_pc.size() != 2) begin
      nerr++;
      $display("FAIL ill_count: done=%b n=%0d want 1 2", done, q_pc.size());
    end
    nvec++;
    if ({q_cls[1], q_ill[1], q_ill[0], illegal} !== {3'd0, 3'b101}) begin
      nerr++;
      $display("FAIL ill_flag: cls=%0d ill=%b%b sticky=%b want 0 10 1",
               q_cls[1], q_ill[1], q_ill[0], illegal);
    end
`else
    nvec++;
    if (!done || q_pc.size() != 3 || q_pc[2] !== 32'd8) begin
      nerr++;
      $display("FAIL ill_count: done=%b n=%0d want 1 3", done, q_pc.size());
    end
    nvec++;
    if ({q_cls[1], q_ill[1], illegal} !== 5'd0) begin
      nerr++;
      $display("FAIL ill_flag: cls=%0d ill=%b now=%b want 0 0 0",
               q_cls[1], q_ill[1], illegal);
    end
`endif
  endtask

  task automatic test_max_pc();
    bit done;
    for (int i = 0; i < 256; i++) rom[i] = 32'h00611020;
    bus.out_ready = 1'b1;
    pulse_start();
    capture(400, done);
    nvec++;
    if (!done || q_pc.size() != 256) begin
      nerr++;
      $display("FAIL maxpc_count: done=%b n=%0d want 1 256",
               done, q_pc.size());
    end
    nvec++;
    if ({q_pc[255], bus.imem_addr} !== {32'd1020, 32'd1020}) begin
      nerr++;
      $display("FAIL maxpc_last: pc=%h addr=%h want 3fc 3fc",
               q_pc[255], bus.imem_addr);
    end
  endtask

  initial begin
    prog[0] = 32'h8D100200;
    prog[1] = 32'h8C220004;
    prog[2] = 32'h01C84818;
    prog[3] = 32'h00611020;
    prog[4] = 32'h00611020;
    prog[5] = 32'h8C220004;
    prog[6] = 32'h01C84818;
    prog[7] = 32'h00611020;
    prog[8] = 32'hADD00100;
    prog[9] = 32'h00000000;
    clear_rom();
    test_reset();
    test_first_fetch();
    test_stall_hold();
    test_stream();
    test_stall_mid();
    test_async_reset();
    test_eop();
    test_illegal();
    test_max_pc();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1);
  end

endmodule
